// File: rtl/renkon_linebuf.sv
// 5x5 sliding-window generator for a raster-order square feature map.
// Four line memories hold the previous rows; the window shifts left once per accepted pixel.
module renkon_linebuf #(
  parameter int DWIDTH = 16,
  parameter int LWIDTH = 10,
  parameter int MAXW   = 32,
  parameter int FSIZE  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              buf_start,
  input  logic [LWIDTH-1:0] img_size,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] pixel_in,
  output logic [DWIDTH-1:0] pixel0,
  output logic [DWIDTH-1:0] pixel1,
  output logic [DWIDTH-1:0] pixel2,
  output logic [DWIDTH-1:0] pixel3,
  output logic [DWIDTH-1:0] pixel4,
  output logic [DWIDTH-1:0] pixel5,
  output logic [DWIDTH-1:0] pixel6,
  output logic [DWIDTH-1:0] pixel7,
  output logic [DWIDTH-1:0] pixel8,
  output logic [DWIDTH-1:0] pixel9,
  output logic [DWIDTH-1:0] pixel10,
  output logic [DWIDTH-1:0] pixel11,
  output logic [DWIDTH-1:0] pixel12,
  output logic [DWIDTH-1:0] pixel13,
  output logic [DWIDTH-1:0] pixel14,
  output logic [DWIDTH-1:0] pixel15,
  output logic [DWIDTH-1:0] pixel16,
  output logic [DWIDTH-1:0] pixel17,
  output logic [DWIDTH-1:0] pixel18,
  output logic [DWIDTH-1:0] pixel19,
  output logic [DWIDTH-1:0] pixel20,
  output logic [DWIDTH-1:0] pixel21,
  output logic [DWIDTH-1:0] pixel22,
  output logic [DWIDTH-1:0] pixel23,
  output logic [DWIDTH-1:0] pixel24,
  output logic              out_valid,
  output logic              frame_done,
  output logic              size_err
);

  localparam int unsigned NPIX  = FSIZE * FSIZE;
  localparam int unsigned NLINE = FSIZE - 1;
  localparam int unsigned AW    = (MAXW > 1) ? $clog2(MAXW) : 1;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t            state_q, state_d;
  logic [LWIDTH-1:0] last_q, last_d;
  logic [LWIDTH-1:0] col_q, col_d;
  logic [LWIDTH-1:0] row_q, row_d;
  logic              size_err_q, size_err_d;
  logic              out_valid_q, out_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              accept, size_ok;
  logic [AW-1:0]     addr;

  logic [DWIDTH-1:0] win_q    [NPIX];
  logic [DWIDTH-1:0] line_mem [NLINE][MAXW];

  assign size_ok = (img_size >= LWIDTH'(FSIZE)) && (img_size <= LWIDTH'(MAXW));
  // buf_start wins over a coincident pixel: that pixel is dropped
  assign accept  = in_valid && (state_q == S_FILL) && !buf_start;
  assign addr    = col_q[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      size_err_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      col_q        <= col_d;
      row_q        <= row_d;
      size_err_q   <= size_err_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    col_d        = col_q;
    row_d        = row_q;
    size_err_d   = size_err_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (buf_start) begin
      col_d  = '0;
      row_d  = '0;
      last_d = img_size - LWIDTH'(1);
      if (size_ok) begin
        state_d    = S_FILL;
        size_err_d = 1'b0;
      end else begin
        state_d    = S_IDLE;
        size_err_d = 1'b1;
      end
    end else if (accept) begin
      out_valid_d = (row_q >= LWIDTH'(FSIZE - 1)) && (col_q >= LWIDTH'(FSIZE - 1));
      if (col_q == last_q) begin
        col_d = '0;
        if (row_q == last_q) begin
          row_d        = '0;
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + LWIDTH'(1);
        end
      end else begin
        col_d = col_q + LWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NPIX; i++) win_q[i] <= '0;
    end else if (accept) begin
      for (int unsigned r = 0; r < FSIZE; r++)
        for (int unsigned c = 0; c + 1 < FSIZE; c++)
          win_q[r*FSIZE + c] <= win_q[r*FSIZE + c + 1];
      for (int unsigned r = 0; r < NLINE; r++)
        win_q[r*FSIZE + FSIZE - 1] <= line_mem[r][addr];
      win_q[NPIX-1] <= pixel_in;
    end
  end

  // Line memories are deliberately unreset; old column data ages out as rows roll through
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned k = 0; k + 1 < NLINE; k++)
        line_mem[k][addr] <= line_mem[k+1][addr];
      line_mem[NLINE-1][addr] <= pixel_in;
    end
  end

  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
  assign size_err   = size_err_q;

  assign pixel0  = win_q[0];
  assign pixel1  = win_q[1];
  assign pixel2  = win_q[2];
  assign pixel3  = win_q[3];
  assign pixel4  = win_q[4];
  assign pixel5  = win_q[5];
  assign pixel6  = win_q[6];
  assign pixel7  = win_q[7];
  assign pixel8  = win_q[8];
  assign pixel9  = win_q[9];
  assign pixel10 = win_q[10];
  assign pixel11 = win_q[11];
  assign pixel12 = win_q[12];
  assign pixel13 = win_q[13];
  assign pixel14 = win_q[14];
  assign pixel15 = win_q[15];
  assign pixel16 = win_q[16];
  assign pixel17 = win_q[17];
  assign pixel18 = win_q[18];
  assign pixel19 = win_q[19];
  assign pixel20 = win_q[20];
  assign pixel21 = win_q[21];
  assign pixel22 = win_q[22];
  assign pixel23 = win_q[23];
  assign pixel24 = win_q[24];

endmodule
